// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier datapath.
//   MULT_WIDTH : default operand width
//   mult_op_e  : the single operation chosen each cycle after priority decode
//   sext()     : sign-extends a MULT_WIDTH value by one bit
package mult_pkg;

  localparam int MULT_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_CLRLD,
    OP_SUB,
    OP_ADD,
    OP_SHIFT
  } mult_op_e;

  function automatic logic [MULT_WIDTH:0] sext(input logic [MULT_WIDTH-1:0] x);
    return {x[MULT_WIDTH-1], x};
  endfunction

endpackage

// File: rtl/add_sub_ext.sv
// WIDTH+1-bit adder/subtractor for the accumulator.
//   a      : accumulator value (signed)
//   s      : operand value (signed)
//   sub    : 1 selects a - s, 0 selects a + s
//   result : sign-extended WIDTH+1-bit sum, wraps silently
// Subtraction reuses the adder: s is inverted and the carry-in is set.
module add_sub_ext #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] s,
  input  logic             sub,
  output logic [WIDTH:0]   result
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] s_ext;

  assign a_ext  = {a[WIDTH-1], a};
  assign s_ext  = {s[WIDTH-1], s} ^ {(WIDTH+1){sub}};
  assign result = a_ext + s_ext + {{WIDTH{1'b0}}, sub};

endmodule

// File: rtl/mult_datapath.sv
// Register/arithmetic datapath for the 8-bit shift-add multiplier.
// Holds the sign bit X, accumulator A and multiplier B; the signed product
// appears in A:B (with X as its sign) after the final shift.
//   Clk    : system clock, rising edge
//   Reset  : synchronous active-low reset
//   Clr_Ld : clear A/X, load B from S
//   Shift  : arithmetic right shift of X:A:B
//   Add    : {X,A} <= A + S
//   Sub    : {X,A} <= A - S (wins over Add when both are set)
//   S      : multiplicand / load value, used combinationally
//   M      : B[0] back to the control FSM
//   X, Aval, Bval : datapath registers
//   Done   : product complete
// Optional build macro MULT_SHIFT_COUNT_EN adds a saturating shift counter
// that drives Done; without it Done is tied low.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clr_Ld,
  input  logic             Shift,
  input  logic             Add,
  input  logic             Sub,
  input  logic [WIDTH-1:0] S,
  output logic             M,
  output logic             X,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Done
);

  mult_op_e       op;
  logic           x_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0] sum;

  always_comb begin
    op = OP_NONE;
    if (Clr_Ld)     op = OP_CLRLD;
    else if (Sub)   op = OP_SUB;
    else if (Add)   op = OP_ADD;
    else if (Shift) op = OP_SHIFT;
  end

  add_sub_ext #(.WIDTH(WIDTH)) u_add_sub (
    .a      (a_q),
    .s      (S),
    .sub    (op == OP_SUB),
    .result (sum)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      x_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      case (op)
        OP_CLRLD: begin
          x_q <= 1'b0;
          a_q <= '0;
          b_q <= S;
        end
        OP_SUB, OP_ADD: begin
          x_q <= sum[WIDTH];
          a_q <= sum[WIDTH-1:0];
        end
        OP_SHIFT: begin
          a_q <= {x_q, a_q[WIDTH-1:1]};
          b_q <= {a_q[0], b_q[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

  assign M    = b_q[0];
  assign X    = x_q;
  assign Aval = a_q;
  assign Bval = b_q;

`ifdef MULT_SHIFT_COUNT_EN
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [CW-1:0] cnt_q;
  logic          done_q;

  // Only shifts that actually execute are counted; the count saturates so
  // extra shifts keep Done asserted.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (op == OP_CLRLD) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (op == OP_SHIFT && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CNT_MAX - 1'b1) done_q <= 1'b1;
    end
  end

  assign Done = done_q;
`else
  assign Done = 1'b0;
`endif

endmodule
